// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES inverse cipher (FIPS-197) with sequential key expansion.
//
// Flow: IDLE -> EXPAND (one key word per cycle) -> INIT (add last round key)
//       -> ROUND (one inverse round per cycle) -> IDLE with a one-cycle valid pulse.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   key    in   32*Nk-bit cipher key, key[32*Nk-1 -: 8] is key byte 0
//   load   in   start strobe, sampled only while ready=1
//   ct     in   128-bit ciphertext, ct[127:120] is state byte 0
//   pt     out  128-bit plaintext, held until the next completion
//   valid  out  one-cycle pulse when pt is updated
//   ready  out  high while IDLE
//
// Optional feature: define AES_DEC_KEY_CACHE_EN to keep the last expanded key.
// A load with the same key then skips EXPAND (latency Nr+1 instead of the full figure).
//
// aes_sbox / aes_inv_sbox are the shared byte-lookup modules; they are kept in this
// file so the block is self-contained.

package aes_dec_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction
endpackage

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    import aes_dec_pkg::*;
    logic [7:0] inv;
    assign inv = gf_inv(a_i);
    assign y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    import aes_dec_pkg::*;
    logic [7:0] aff;
    // Undo the affine transform first, then invert in GF(2^8).
    assign aff = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
    assign y_o = gf_inv(aff);
endmodule

module aes_decrypt #(
    parameter int Nk = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [32*Nk-1:0]  key,
    input  logic              load,
    input  logic [127:0]      ct,
    output logic [127:0]      pt,
    output logic              valid,
    output logic              ready
);
    import aes_dec_pkg::*;

    localparam int Nr = Nk + 6;
    localparam int NW = 4 * (Nr + 1);

    typedef enum logic [1:0] {IDLE, EXPAND, INIT, ROUND} state_e;

    state_e        fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  pt_q, pt_d;
    logic          valid_q, valid_d;
    logic [5:0]    wcnt_q, wcnt_d;     // word index i being expanded
    logic [2:0]    kmod_q, kmod_d;     // i % Nk, tracked incrementally
    logic [3:0]    round_q, round_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [31:0]   w_q [NW];
    logic          key_wr, word_wr;
`ifdef AES_DEC_KEY_CACHE_EN
    logic              cache_ok_q, cache_ok_d;
    logic [32*Nk-1:0]  cached_key_q, cached_key_d;
`endif

    // ---------------- key expansion datapath ----------------
    logic [31:0] temp_prev, sub_in, sub_out, temp, w_new;

    assign temp_prev = w_q[wcnt_q - 6'd1];
    assign sub_in    = (kmod_q == 3'd0) ? {temp_prev[23:0], temp_prev[31:24]} : temp_prev;

    for (genvar j = 0; j < 4; j++) begin : g_sub_word
        aes_sbox u_sbox (.a_i(sub_in[8*j +: 8]), .y_o(sub_out[8*j +: 8]));
    end

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        temp = temp_prev;
        if (kmod_q == 3'd0)
            temp = sub_out ^ {rcon_q, 24'h0};
        else if (Nk == 8 && kmod_q == 3'd4)
            temp = sub_out;
    end

    assign w_new = w_q[wcnt_q - 6'(Nk)] ^ temp;

    // ---------------- inverse round datapath ----------------
    logic [3:0]   rk_idx;
    logic [5:0]   rk_base;
    logic [127:0] rk;
    logic [127:0] s_round;

    assign rk_idx  = (fsm_q == INIT) ? 4'(Nr) : round_q;
    assign rk_base = {rk_idx, 2'b00};
    assign rk      = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};

    // InvShiftRows is pure wiring: row r of column c comes from column (c-r) mod 4.
    for (genvar b = 0; b < 16; b++) begin : g_inv_bytes
        localparam int R   = b % 4;
        localparam int C   = b / 4;
        localparam int SRC = 4 * ((C - R + 4) % 4) + R;
        logic [7:0] isb_out;
        aes_inv_sbox u_inv_sbox (.a_i(state_q[127-8*SRC -: 8]), .y_o(isb_out));
        assign s_round[127-8*b -: 8] = isb_out ^ rk[127-8*b -: 8];
    end

    // Coefficients 0e/0b/0d/09 assembled from x2, x4, x8 xtime chains.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
        logic [7:0]   a, x2, x4, x8;
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a  = st[127-8*(4*c+r) -: 8];
                x2 = xtime(a);
                x4 = xtime(x2);
                x8 = xtime(x4);
                m9[r] = x8 ^ a;
                mb[r] = x8 ^ x2 ^ a;
                md[r] = x8 ^ x4 ^ a;
                me[r] = x8 ^ x4 ^ x2;
            end
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return res;
    endfunction

    // ---------------- control ----------------
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        pt_d    = pt_q;
        valid_d = 1'b0;
        wcnt_d  = wcnt_q;
        kmod_d  = kmod_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        key_wr  = 1'b0;
        word_wr = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_ok_d   = cache_ok_q;
        cached_key_d = cached_key_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (load) begin
                    state_d = ct;
                    fsm_d   = EXPAND;
                    key_wr  = 1'b1;
                    wcnt_d  = 6'(Nk);
                    kmod_d  = 3'd0;
                    rcon_d  = 8'h01;
`ifdef AES_DEC_KEY_CACHE_EN
                    cached_key_d = key;
                    if (cache_ok_q && key == cached_key_q) begin
                        // Round-key store already holds this key's schedule.
                        fsm_d  = INIT;
                        key_wr = 1'b0;
                    end else begin
                        cache_ok_d = 1'b0;
                    end
`endif
                end
            end
            EXPAND: begin
                word_wr = 1'b1;
                wcnt_d  = wcnt_q + 6'd1;
                kmod_d  = (kmod_q == 3'(Nk - 1)) ? 3'd0 : kmod_q + 3'd1;
                if (kmod_q == 3'd0) rcon_d = xtime(rcon_q);
                if (wcnt_q == 6'(NW - 1)) begin
                    fsm_d = INIT;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_ok_d = 1'b1;
`endif
                end
            end
            INIT: begin
                state_d = state_q ^ rk;
                round_d = 4'(Nr - 1);
                fsm_d   = ROUND;
            end
            ROUND: begin
                if (round_q != 4'd0) begin
                    state_d = inv_mix_columns(s_round);
                    round_d = round_q - 4'd1;
                end else begin
                    pt_d    = s_round;
                    valid_d = 1'b1;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            pt_q    <= '0;
            valid_q <= 1'b0;
            wcnt_q  <= '0;
            kmod_q  <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_ok_q   <= 1'b0;
            cached_key_q <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            pt_q    <= pt_d;
            valid_q <= valid_d;
            wcnt_q  <= wcnt_d;
            kmod_q  <= kmod_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_ok_q   <= cache_ok_d;
            cached_key_q <= cached_key_d;
`endif
        end
    end

    // NOTE: the round-key store has no reset; each word is written before it is ever read.
    always_ff @(posedge clk) begin
        if (key_wr)
            for (int k = 0; k < Nk; k++) w_q[k] <= key[32*(Nk-1-k) +: 32];
        if (word_wr)
            w_q[wcnt_q] <= w_new;
    end

    assign pt    = pt_q;
    assign valid = valid_q;
    assign ready = (fsm_q == IDLE);

endmodule

// File: tb/tb_aes_decrypt.sv
// Testbench for aes_decrypt: three instances (Nk=4/6/8) checked against a
// byte-level AES inverse-cipher reference model and FIPS-197 known answers.
`timescale 1ns/1ps
module tb_aes_decrypt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         load4, load6, load8;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic [127:0] ct4, ct6, ct8, pt4, pt6, pt8;
    logic         valid4, valid6, valid8, ready4, ready6, ready8;

    aes_decrypt #(.Nk(4)) dut4 (.clk(clk), .rst_n(rst_n), .key(key4), .load(load4),
                                .ct(ct4), .pt(pt4), .valid(valid4), .ready(ready4));
    aes_decrypt #(.Nk(6)) dut6 (.clk(clk), .rst_n(rst_n), .key(key6), .load(load6),
                                .ct(ct6), .pt(pt6), .valid(valid6), .ready(ready6));
    aes_decrypt #(.Nk(8)) dut8 (.clk(clk), .rst_n(rst_n), .key(key8), .load(load8),
                                .ct(ct8), .pt(pt8), .valid(valid8), .ready(ready8));

`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    bit           cache_valid [9];
    logic [255:0] cache_key   [9];

    // ---------------- reference model ----------------
    // S-box built by walking the generator 3 and its inverse (p*3, q/3).
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);
    endtask

    // Polynomial product then reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    function automatic logic [127:0] ref_decrypt(input int nk, input logic [255:0] k,
                                                 input logic [127:0] c);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coef [4];
        logic [7:0]   acc, rc;
        logic [31:0]  tw;
        logic [127:0] res;
        int nr;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[32*(nk-1-i) +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tw = w[i-1];
            if (i % nk == 0) begin
                tw = sub_word({tw[23:0], tw[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tw = sub_word(tw);
            end
            w[i] = w[i-nk] ^ tw;
        end
        for (int b = 0; b < 16; b++) s[b] = c[127-8*b -: 8] ^ w[4*nr + b/4][31-8*(b%4) -: 8];
        for (int r = nr - 1; r >= 0; r--) begin
            for (int b = 0; b < 16; b++)
                t[b] = inv_sbox[s[4*(((b/4) - (b%4) + 4) % 4) + (b%4)]]
                       ^ w[4*r + b/4][31-8*(b%4) -: 8];
            if (r > 0) begin
                for (int col = 0; col < 4; col++)
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++)
                            acc = acc ^ gmul(t[4*col+j], coef[(j - row + 4) % 4]);
                        s[4*col+row] = acc;
                    end
            end else begin
                s = t;
            end
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    function automatic int full_lat(input int nk);
        return (4*(nk+7) - nk) + 1 + (nk + 6);
    endfunction

    function automatic int exp_lat(input int nk, input logic [255:0] k);
        if (CACHE_EN && cache_valid[nk] && cache_key[nk] == k) return nk + 7;
        return full_lat(nk);
    endfunction

    function automatic logic [255:0] rand_key(input int nk);
        logic [255:0] k;
        k = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return k >> (256 - 32*nk);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- DUT access by key size ----------------
    task automatic drive(input int nk, input logic ld, input logic [255:0] k, input logic [127:0] c);
        case (nk)
            4: begin load4 = ld; key4 = k[127:0]; ct4 = c; end
            6: begin load6 = ld; key6 = k[191:0]; ct6 = c; end
            default: begin load8 = ld; key8 = k; ct8 = c; end
        endcase
    endtask

    function automatic logic get_valid(input int nk);
        return (nk == 4) ? valid4 : (nk == 6) ? valid6 : valid8;
    endfunction

    function automatic logic get_ready(input int nk);
        return (nk == 4) ? ready4 : (nk == 6) ? ready6 : ready8;
    endfunction

    function automatic logic [127:0] get_pt(input int nk);
        return (nk == 4) ? pt4 : (nk == 6) ? pt6 : pt8;
    endfunction

    // One complete operation: checks plaintext, latency, ready low while busy,
    // single-cycle valid. Inputs are scrambled right after the load edge.
    task automatic run_op(input string name, input int nk, input logic [255:0] k,
                          input logic [127:0] c, output logic [127:0] got);
        logic [127:0] exp_pt;
        int  lat, cyc;
        bit  seen, rdy_bad;
        exp_pt = ref_decrypt(nk, k, c);
        lat    = exp_lat(nk, k);
        got    = 'x;
        @(negedge clk); drive(nk, 1'b1, k, c);
        @(negedge clk); drive(nk, 1'b0, rand_key(nk), rand128());
        cyc = 0; seen = 0; rdy_bad = (get_ready(nk) !== 1'b0);
        while (!seen && cyc < 200) begin
            @(negedge clk); cyc++;
            if (get_valid(nk) === 1'b1) seen = 1;
            else if (get_ready(nk) !== 1'b0) rdy_bad = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout: no valid within %0d cycles, required %0d", name, cyc, lat);
        end else begin
            got = get_pt(nk);
            checks++;
            if (cyc != lat) begin
                failures++;
                $display("FAIL %s latency: got %0d required %0d", name, cyc, lat);
            end
            checks++;
            if (got !== exp_pt) begin
                failures++;
                $display("FAIL %s pt: got %h required %h", name, got, exp_pt);
            end
            cache_valid[nk] = 1'b1;
            cache_key[nk]   = k;
            @(negedge clk);
            checks++;
            if (get_valid(nk) !== 1'b0) begin
                failures++;
                $display("FAIL %s valid width: got %b one cycle later, required 0", name, get_valid(nk));
            end
        end
        if (rdy_bad) begin
            failures++;
            $display("FAIL %s ready while busy: got 1 required 0", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(4, 1'b0, '0, '0); drive(6, 1'b0, '0, '0); drive(8, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        checks++; if (pt4 !== 128'h0) begin failures++; $display("FAIL reset pt: got %h required 0", pt4); end
        checks++; if (valid4 !== 1'b0) begin failures++; $display("FAIL reset valid: got %b required 0", valid4); end
        checks++; if (ready4 !== 1'b1) begin failures++; $display("FAIL reset ready4: got %b required 1", ready4); end
        checks++; if (ready6 !== 1'b1 || ready8 !== 1'b1) begin
            failures++; $display("FAIL reset ready6/8: got %b/%b required 1/1", ready6, ready8);
        end
        for (int i = 0; i < 9; i++) cache_valid[i] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known_answers();
        logic [127:0] got;
        logic [127:0] pt_c;
        pt_c = 128'h00112233445566778899aabbccddeeff;
        run_op("kat_b_nk4", 4, 256'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32, got);
        checks++; if (got !== 128'h3243f6a8885a308d313198a2e0370734) begin
            failures++; $display("FAIL kat_b_nk4 const: got %h required 3243f6a8885a308d313198a2e0370734", got);
        end
        run_op("kat_c_nk4", 4, 256'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, got);
        checks++; if (got !== pt_c) begin failures++; $display("FAIL kat_c_nk4 const: got %h required %h", got, pt_c); end
        run_op("kat_c_nk6", 6, 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
               128'hdda97ca4864cdfe06eaf70a0ec0d7191, got);
        checks++; if (got !== pt_c) begin failures++; $display("FAIL kat_c_nk6 const: got %h required %h", got, pt_c); end
        run_op("kat_c_nk8", 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h8ea2b7ca516745bfeafc49904b496089, got);
        checks++; if (got !== pt_c) begin failures++; $display("FAIL kat_c_nk8 const: got %h required %h", got, pt_c); end
    endtask

    task automatic test_random();
        logic [127:0] got;
        int nks [3];
        nks[0] = 4; nks[1] = 6; nks[2] = 8;
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < 4; i++)
                run_op($sformatf("rand_nk%0d_%0d", nks[n], i), nks[n], rand_key(nks[n]), rand128(), got);
    endtask

    task automatic test_ignore_load();
        logic [255:0] k;
        logic [127:0] c, exp_pt;
        int lat, cyc;
        bit seen;
        k = rand_key(4); c = rand128();
        exp_pt = ref_decrypt(4, k, c);
        lat    = exp_lat(4, k);
        @(negedge clk); drive(4, 1'b1, k, c);
        @(negedge clk); drive(4, 1'b0, k, c);
        cyc = 0; seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk); cyc++;
            if (valid4 === 1'b1) seen = 1;
            else drive(4, (cyc == 10), rand_key(4), rand128());
        end
        drive(4, 1'b0, k, c);
        checks++;
        if (!seen) begin
            failures++; $display("FAIL ignore_load timeout: no valid within %0d cycles", cyc);
        end else begin
            checks++; if (cyc != lat) begin failures++; $display("FAIL ignore_load latency: got %0d required %0d", cyc, lat); end
            checks++; if (pt4 !== exp_pt) begin failures++; $display("FAIL ignore_load pt: got %h required %h", pt4, exp_pt); end
            cache_valid[4] = 1'b1; cache_key[4] = k;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [127:0] got;
        int cyc;
        bit stray;
        @(negedge clk); drive(4, 1'b1, rand_key(4), rand128());
        @(negedge clk); drive(4, 1'b0, '0, '0);
        cyc = 0;
        while (cyc < 30) begin @(negedge clk); cyc++; end
        rst_n = 1'b0;
        #1;
        checks++; if (pt4 !== 128'h0) begin failures++; $display("FAIL abort pt: got %h required 0", pt4); end
        checks++; if (valid4 !== 1'b0) begin failures++; $display("FAIL abort valid: got %b required 0", valid4); end
        checks++; if (ready4 !== 1'b1) begin failures++; $display("FAIL abort ready: got %b required 1", ready4); end
        for (int i = 0; i < 9; i++) cache_valid[i] = 1'b0;
        while (cyc < 33) begin @(negedge clk); cyc++; end
        rst_n = 1'b1;
        stray = 0;
        repeat (80) begin @(negedge clk); if (valid4 !== 1'b0) stray = 1; end
        checks++; if (stray) begin failures++; $display("FAIL abort stray valid: got 1 required 0"); end
        run_op("after_reset", 4, rand_key(4), rand128(), got);
    endtask

    task automatic test_back_to_back();
        logic [255:0] k;
        logic [127:0] c [2];
        logic [127:0] exp_pt;
        int lat, cyc;
        bit seen;
        k = rand_key(4); c[0] = rand128(); c[1] = rand128();
        @(negedge clk); drive(4, 1'b1, k, c[0]);
        for (int op = 0; op < 2; op++) begin
            exp_pt = ref_decrypt(4, k, c[op]);
            lat    = exp_lat(4, k);
            cyc = -1; seen = 0;
            while (!seen && cyc < 200) begin
                @(negedge clk); cyc++;
                if (valid4 === 1'b1) seen = 1;
            end
            checks++;
            if (!seen) begin
                failures++; $display("FAIL b2b%0d timeout: no valid within %0d cycles", op, cyc);
            end else begin
                checks++; if (cyc != lat) begin failures++; $display("FAIL b2b%0d latency: got %0d required %0d", op, cyc, lat); end
                checks++; if (pt4 !== exp_pt) begin failures++; $display("FAIL b2b%0d pt: got %h required %h", op, pt4, exp_pt); end
                cache_valid[4] = 1'b1; cache_key[4] = k;
            end
            // load stays high for the second op, accepted in the valid cycle
            drive(4, (op == 0), k, c[1]);
        end
        @(negedge clk);
        checks++; if (ready4 !== 1'b1) begin failures++; $display("FAIL b2b idle: ready got %b required 1", ready4); end
    endtask

    task automatic test_key_cache();
        logic [127:0] got;
        logic [255:0] ka, kb;
        ka = rand_key(4);
        kb = rand_key(4);
        run_op("cache_a1", 4, ka, rand128(), got);
        run_op("cache_b",  4, kb, rand128(), got);
        run_op("cache_a2", 4, ka, rand128(), got);
        run_op("cache_a3", 4, ka, rand128(), got);
    endtask

    initial begin
        build_tables();
        test_reset();
        test_known_answers();
        test_random();
        test_ignore_load();
        test_reset_abort();
        test_back_to_back();
        test_key_cache();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
